// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tone_decoder
// Description : Measures the period and high time of an asynchronous square
//               wave (PWM sound line), reports each measurement with a
//               one-cycle strobe, and tracks period stability (lock) and
//               absence of tone (silence).
// Revision    : 1.0 - initial release
// ============================================================================
module tone_decoder #(
    parameter int BW           = 16,
    parameter int TOLERANCE    = 2,
    parameter int STABLE_COUNT = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sound_i,
    output logic [BW-1:0] period_o,
    output logic [BW-1:0] highTime_o,
    output logic          valid_o,
    output logic          locked_o,
    output logic          silence_o
);

    // Match counter must be able to hold STABLE_COUNT itself.
    localparam int              c_MW      = (STABLE_COUNT < 1) ? 1 : $clog2(STABLE_COUNT + 1);
    localparam logic [BW-1:0]   c_CNT_MAX = {BW{1'b1}};
    localparam logic [BW-1:0]   c_CNT_ONE = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [c_MW-1:0] c_STABLE  = c_MW'(STABLE_COUNT);
    localparam logic [BW:0]     c_TOL     = (BW+1)'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_SILENT  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Front end: synchroniser, delayed level and registered rise
    // ------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;
    logic rise_q,  rise_d;

    // ------------------------------------------------------------------
    // Measurement counters
    // ------------------------------------------------------------------
    logic [BW-1:0] period_cnt_q, period_cnt_d;
    logic [BW-1:0] high_cnt_q,   high_cnt_d;
    logic          w_period_sat;
    logic          w_high_sat;
    logic          w_sat;

    // ------------------------------------------------------------------
    // Comparison and FSM state
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [BW-1:0]   prev_period_q, prev_period_d;
    logic            first_q, first_d;
    logic [c_MW-1:0] match_cnt_q, match_cnt_d;
    logic [c_MW-1:0] w_match_inc;
    logic [BW:0]     w_new_ext;
    logic [BW:0]     w_prev_ext;
    logic [BW:0]     w_diff;
    logic            w_match;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [BW-1:0] period_q,  period_d;
    logic [BW-1:0] high_q,    high_d;
    logic          valid_q,   valid_d;
    logic          locked_q,  locked_d;
    logic          silence_q, silence_d;

    assign period_o   = period_q;
    assign highTime_o = high_q;
    assign valid_o    = valid_q;
    assign locked_o   = locked_q;
    assign silence_o  = silence_q;

    // Two-flop synchroniser, delayed copy, and rise detect registered once.
    always_comb begin
        sync1_d = sound_i;
        sync2_d = sync1_q;
        level_d = sync2_q;
        rise_d  = sync2_q & ~level_q;
    end

    // Front-end flops: synchroniser chain and rise register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // Period and high-time counters; both restart at 1 on a rise so that a
    // tone of P clocks reads P at the following rise. level_q is aligned with
    // rise_q, so the rise cycle itself is counted as high.
    always_comb begin
        w_period_sat = (period_cnt_q == c_CNT_MAX);
        w_high_sat   = (high_cnt_q == c_CNT_MAX);
        w_sat        = w_period_sat | w_high_sat;

        period_cnt_d = period_cnt_q;
        if (rise_q) begin
            period_cnt_d = c_CNT_ONE;
        end else if (!w_period_sat) begin
            period_cnt_d = period_cnt_q + c_CNT_ONE;
        end

        high_cnt_d = high_cnt_q;
        if (rise_q) begin
            high_cnt_d = c_CNT_ONE;
        end else if (level_q && !w_high_sat) begin
            high_cnt_d = high_cnt_q + c_CNT_ONE;
        end
    end

    // Counter flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
        end
    end

    // Absolute period difference in BW+1 bits so it can never overflow.
    always_comb begin
        w_new_ext  = {1'b0, period_cnt_q};
        w_prev_ext = {1'b0, prev_period_q};
        if (w_new_ext >= w_prev_ext) begin
            w_diff = w_new_ext - w_prev_ext;
        end else begin
            w_diff = w_prev_ext - w_new_ext;
        end
        w_match     = (w_diff <= c_TOL);
        w_match_inc = (match_cnt_q == c_STABLE) ? match_cnt_q
                                                : match_cnt_q + {{(c_MW-1){1'b0}}, 1'b1};
    end

    // Next-state logic: arming, measurement capture, lock tracking, and
    // drop to silence on counter saturation (which outranks a rise).
    always_comb begin
        state_d       = state_q;
        prev_period_d = prev_period_q;
        first_d       = first_q;
        match_cnt_d   = match_cnt_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_d       = 1'b0;

        case (state_q)
            ST_SILENT: begin
                if (rise_q && !w_sat) begin
                    state_d     = ST_ACQUIRE;
                    first_d     = 1'b1;
                    match_cnt_d = '0;
                end
            end

            ST_ACQUIRE, ST_LOCKED: begin
                if (w_sat) begin
                    state_d     = ST_SILENT;
                    match_cnt_d = '0;
                end else if (rise_q) begin
                    period_d      = period_cnt_q;
                    high_d        = high_cnt_q;
                    valid_d       = 1'b1;
                    prev_period_d = period_cnt_q;
                    if (first_q) begin
                        // First measurement after arming only seeds the reference.
                        first_d     = 1'b0;
                        match_cnt_d = '0;
                    end else if (w_match) begin
                        match_cnt_d = w_match_inc;
                        if (w_match_inc == c_STABLE) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                        state_d     = ST_ACQUIRE;
                    end
                end
            end

            default: begin
                state_d     = ST_SILENT;
                match_cnt_d = '0;
            end
        endcase

        locked_d  = (state_d == ST_LOCKED);
        silence_d = (state_d == ST_SILENT);
    end

    // FSM state, measurement registers and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_SILENT;
            prev_period_q <= '0;
            first_q       <= 1'b0;
            match_cnt_q   <= '0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            silence_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            prev_period_q <= prev_period_d;
            first_q       <= first_d;
            match_cnt_q   <= match_cnt_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            silence_q     <= silence_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter BW, default 16: width of period and high-time measurements.
REQ-002 SHALL have parameter TOLERANCE, default 2: maximum absolute period difference, in clocks, counted as a match.
REQ-003 SHALL have parameter STABLE_COUNT, default 3: number of consecutive matches required for lock.
REQ-004 SHALL have port clk_i, input, 1 bit: single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port sound_i, input, 1 bit: asynchronous square-wave tone input (the PWM sound line).
REQ-007 SHALL have port period_o, output, BW bits: last measured period in clocks.
REQ-008 SHALL have port highTime_o, output, BW bits: last measured high time in clocks.
REQ-009 SHALL have port valid_o, output, 1 bit: one-cycle strobe when period_o and highTime_o update.
REQ-010 SHALL have port locked_o, output, 1 bit: high while the measured period is stable.
REQ-011 SHALL have port silence_o, output, 1 bit: high while no tone is being measured.

Function
REQ-012 SHALL synchronise sound_i through two flip-flops, then register the synchronised level once more for edge detection.
REQ-013 SHALL detect a rise in any cycle where the synchronised level is 1 and its delayed copy is 0.
REQ-014 SHALL run a period counter that loads 1 on a rise cycle and increments by 1 otherwise, so a tone of exactly P clocks captures P.
REQ-015 SHALL run a high counter that loads 1 on a rise cycle, increments on cycles with synchronised level 1, and holds on cycles with level 0.
REQ-016 SHALL saturate both counters at 2^BW-1, with no wrap-around.
REQ-017 SHALL use a three-state FSM: SILENT, ACQUIRE, LOCKED; its reset state is SILENT.
REQ-018 SHALL, in SILENT, move to ACQUIRE on a rise (arming only), with no valid_o, and hold silence_o at 1.
REQ-019 SHALL, on a rise in ACQUIRE or LOCKED, register the period counter into period_o and the high counter into highTime_o, and pulse valid_o on the next cycle.
REQ-020 SHALL give valid_o a latency of 4 clock edges from the first edge that samples sound_i high (2 sync + 1 edge + 1 output register).
REQ-021 SHALL treat a measurement as a match when |new period - previous period| <= TOLERANCE, using unsigned BW+1-bit subtraction with no overflow.
REQ-022 SHALL not compare the first measurement after arming; that measurement only initialises the previous period.
REQ-023 SHALL increment a match counter on a match (saturating at STABLE_COUNT) and clear it on a mismatch.
REQ-024 SHALL move ACQUIRE to LOCKED when the match counter reaches STABLE_COUNT.
REQ-025 SHALL move LOCKED to ACQUIRE on any mismatch, with the match counter cleared.
REQ-026 SHALL move any state to SILENT when either counter saturates, i.e. input stuck low or stuck high.
REQ-027 SHALL keep period_o and highTime_o holding their last values in SILENT.
REQ-028 SHALL give saturation priority over a rise in the same cycle; that rise is ignored and not armed.
REQ-029 SHALL drive locked_o = (state == LOCKED) and silence_o = (state == SILENT), both registered.
REQ-030 SHALL support a minimum measurable period of 2 clocks (1 high, 1 low); shorter input pulses may be missed, with no other requirement.

Reset
REQ-031 SHALL, while rst_i is high, immediately force: state SILENT, period_o 0, highTime_o 0, valid_o 0, locked_o 0, silence_o 1, counters 0, match counter 0, synchroniser flops 0.
REQ-032 SHALL restart on release of rst_i mid-tone at SILENT, and require a fresh arming rise before any valid_o.

Verification
REQ-033 SHALL be verified with a square wave of period 100 and high 50 (defaults): the first valid_o arrives at the second rise with period_o=100, highTime_o=50; locked_o rises with the 4th valid_o.
REQ-034 SHALL be verified with locked periods alternating 100/102: locked_o stays 1; then a step to 110 causes locked_o to drop on that valid_o, and it re-locks after 3 further periods of 110.
REQ-035 SHALL be verified by stopping the input low after lock: silence_o=1 and locked_o=0 once the counter reaches 65535, with period_o held at 100.
REQ-036 SHALL be verified by asserting rst_i for 1 cycle mid-tone: outputs go to reset values at once, and no valid_o occurs until the second rise after release.
REQ-037 SHALL be verified with a period-2 input (1 high, 1 low): period_o=2, highTime_o=1, with lock after 4 valid_o.
REQ-038 SHALL be verified with sound_i held high for 70000 cycles: silence_o asserts with no valid_o during the hold.
